cache_controller_param: RTL and testbench

Parametrised N-way set-associative write-back cache controller with true-LRU replacement and selectable write-allocate / write-around policy on write misses. It sits between a CPU-side valid/ready request port and a block-wide memory port. Memory latency is variable and governed by a req/ack handshake rather than a fixed delay. It also provides saturating hit and miss counters for performance measurement.

---
 rtl/cache_controller_param.sv | 233 +++++++++++++++++++++++
 tb/tb_cache_controller_param.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller_param.sv
`default_nettype none
// ============================================================================
// Module : cache_controller_param
// N-way set-associative write-back cache controller with true-LRU replacement,
// write-allocate or write-around on write misses, and saturating hit/miss counters.
// Rev    : 1.0
// ============================================================================
module cache_controller_param #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int NUM_WAYS        = 4,
  parameter int NUM_SETS        = 64,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int WRITE_ALLOC     = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cpu_valid,
  output logic                              cpu_ready,
  input  logic                              cpu_rw,
  input  logic [ADDR_W-1:0]                 cpu_addr,
  input  logic [DATA_W-1:0]                 cpu_wdata,
  output logic [DATA_W-1:0]                 cpu_rdata,
  output logic                              cpu_done,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic                              mem_word,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W*WORDS_PER_BLOCK-1:0] mem_wdata,
  input  logic [DATA_W*WORDS_PER_BLOCK-1:0] mem_rdata,
  input  logic                              mem_ack,
  output logic [31:0]                       hit_cnt,
  output logic [31:0]                       miss_cnt
);

  localparam int LINE_W = DATA_W * WORDS_PER_BLOCK;
  localparam int BOFF_W = $clog2(DATA_W / 8);
  localparam int WOFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int AQ_W   = ADDR_W - BOFF_W;
  localparam int TAG_W  = AQ_W - WOFF_W - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_RESPOND, S_WRITEBACK, S_REFILL, S_WRITE_AROUND
  } state_t;

  state_t                state_q;
  logic [AQ_W-1:0]       addr_q;
  logic                  rw_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [WAY_W-1:0]      victim_q;
  logic                  cpu_done_q;
  logic [DATA_W-1:0]     cpu_rdata_q;
  logic                  mem_req_q, mem_we_q, mem_word_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [LINE_W-1:0]     mem_wdata_q;
  logic [31:0]           hit_cnt_q, miss_cnt_q;

  logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]     data_q  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
  logic [WAY_W-1:0]      age_q   [NUM_SETS][NUM_WAYS];

  logic [TAG_W-1:0]      tag;
  logic [IDX_W-1:0]      idx;
  logic [WOFF_W-1:0]     off;
  logic                  hit, inv_any, refill_ack;
  logic [WAY_W-1:0]      hit_way, inv_way, lru_way, victim;
  logic                  line_we_d, tag_we_d, touch_d;
  logic [WAY_W-1:0]      line_way_d;
  logic [LINE_W-1:0]     line_d;
  logic                  w_unused;

  assign tag        = addr_q[AQ_W-1 -: TAG_W];
  assign idx        = addr_q[WOFF_W +: IDX_W];
  assign off        = addr_q[WOFF_W-1:0];
  assign refill_ack = (state_q == S_REFILL) && mem_req_q && mem_ack;
  assign w_unused   = &{1'b0, cpu_addr[BOFF_W-1:0]};

  assign cpu_ready = (state_q == S_IDLE) && !cpu_done_q;
  assign cpu_done  = cpu_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_word  = mem_word_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  // Descending scan so the lowest matching/invalid way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (age_q[idx][w] == WAY_W'(NUM_WAYS - 1)) lru_way = WAY_W'(w);
    end
    victim = inv_any ? inv_way : lru_way;
  end

  always_comb begin
    line_we_d  = 1'b0;
    tag_we_d   = 1'b0;
    line_way_d = hit_way;
    line_d     = data_q[idx][hit_way];
    if (state_q == S_LOOKUP && hit && rw_q) begin
      line_we_d = 1'b1;
      line_d[int'(off)*DATA_W +: DATA_W] = wdata_q;
    end else if (refill_ack) begin
      line_we_d  = 1'b1;
      tag_we_d   = 1'b1;
      line_way_d = victim_q;
      line_d     = mem_rdata;
      if (rw_q) line_d[int'(off)*DATA_W +: DATA_W] = wdata_q;
    end
    touch_d = (state_q == S_LOOKUP && hit) || refill_ack;
  end

  always_ff @(posedge clk) begin
    if (line_we_d) data_q[idx][line_way_d] <= line_d;
    if (tag_we_d)  tag_q[idx][line_way_d]  <= tag;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      victim_q    <= '0;
      cpu_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_word_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      cpu_done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cpu_valid && !cpu_done_q) begin
          addr_q  <= cpu_addr[ADDR_W-1:BOFF_W];
          rw_q    <= cpu_rw;
          wdata_q <= cpu_wdata;
          state_q <= S_LOOKUP;
        end
        S_LOOKUP: if (hit) begin
          if (rw_q) dirty_q[idx][hit_way] <= 1'b1;
          else      cpu_rdata_q <= data_q[idx][hit_way][int'(off)*DATA_W +: DATA_W];
          if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
          state_q <= S_RESPOND;
        end else begin
          if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
          victim_q  <= victim;
          mem_req_q <= 1'b1;
          if (rw_q && WRITE_ALLOC == 0) begin
            mem_we_q    <= 1'b1;
            mem_word_q  <= 1'b1;
            mem_addr_q  <= {addr_q, {BOFF_W{1'b0}}};
            mem_wdata_q <= LINE_W'(wdata_q);
            state_q     <= S_WRITE_AROUND;
          end else if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
            mem_we_q    <= 1'b1;
            mem_word_q  <= 1'b0;
            mem_addr_q  <= {tag_q[idx][victim], idx, {(WOFF_W+BOFF_W){1'b0}}};
            mem_wdata_q <= data_q[idx][victim];
            state_q     <= S_WRITEBACK;
          end else begin
            mem_we_q    <= 1'b0;
            mem_word_q  <= 1'b0;
            mem_addr_q  <= {addr_q[AQ_W-1:WOFF_W], {(WOFF_W+BOFF_W){1'b0}}};
            state_q     <= S_REFILL;
          end
        end
        S_WRITEBACK: if (mem_req_q && mem_ack) begin
          mem_req_q               <= 1'b0;
          dirty_q[idx][victim_q]  <= 1'b0;
          state_q                 <= S_REFILL;
        end
        // Entered with mem_req low after a writeback: issue the read one cycle later.
        S_REFILL: if (!mem_req_q) begin
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_word_q <= 1'b0;
          mem_addr_q <= {addr_q[AQ_W-1:WOFF_W], {(WOFF_W+BOFF_W){1'b0}}};
        end else if (mem_ack) begin
          mem_req_q              <= 1'b0;
          valid_q[idx][victim_q] <= 1'b1;
          dirty_q[idx][victim_q] <= rw_q;
          if (!rw_q) cpu_rdata_q <= mem_rdata[int'(off)*DATA_W +: DATA_W];
          state_q <= S_RESPOND;
        end
        S_WRITE_AROUND: if (mem_req_q && mem_ack) begin
          mem_req_q <= 1'b0;
          state_q   <= S_RESPOND;
        end
        S_RESPOND: begin
          cpu_done_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (touch_d) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (age_q[idx][w] < age_q[idx][line_way_d]) age_q[idx][w] <= age_q[idx][w] + 1'b1;
        end
        age_q[idx][line_way_d] <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_controller_param.sv
`default_nettype none
// ============================================================================
// Module : tb_cache_controller_param
// Directed scoreboard bench: one write-allocate and one write-around instance.
// Rev    : 1.0
// ============================================================================
module tb_cache_controller_param;

  typedef struct {
    logic         we;
    logic         word;
    logic [31:0]  addr;
    logic [255:0] wd;
    logic         chk_wd;
    logic [255:0] rd;
    int           dly;
  } mem_t;

  typedef struct {
    logic        rw;
    logic [31:0] rdata;
    int          lat;
  } cpu_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sel = 1'b0;
  logic         cpu_valid = 1'b0, cpu_rw = 1'b0, mem_ack = 1'b0;
  logic [31:0]  cpu_addr = '0, cpu_wdata = '0;
  logic [255:0] mem_rdata = '0;

  logic         a_ready, a_done, a_req, a_we, a_word, b_ready, b_done, b_req, b_we, b_word;
  logic [31:0]  a_rdata, a_addr, a_hit, a_miss, b_rdata, b_addr, b_hit, b_miss;
  logic [255:0] a_wdata, b_wdata;

  logic         o_ready, o_done, o_req, o_we, o_word;
  logic [31:0]  o_rdata, o_addr, o_hit, o_miss;
  logic [255:0] o_wdata;

  mem_t        exp_mem[$];
  cpu_t        exp_cpu[$];
  int          n_vec = 0, n_err = 0;
  int          exp_hits = 0, exp_misses = 0;
  logic [31:0] last_rd = '0;

  always #5 clk = ~clk;

  cache_controller_param #(.WRITE_ALLOC(1)) dut_a (
    .clk(clk), .rst(rst), .cpu_valid(cpu_valid & ~sel), .cpu_ready(a_ready),
    .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(a_rdata),
    .cpu_done(a_done), .mem_req(a_req), .mem_we(a_we), .mem_word(a_word),
    .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack & ~sel), .hit_cnt(a_hit), .miss_cnt(a_miss));

  cache_controller_param #(.WRITE_ALLOC(0)) dut_b (
    .clk(clk), .rst(rst), .cpu_valid(cpu_valid & sel), .cpu_ready(b_ready),
    .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(b_rdata),
    .cpu_done(b_done), .mem_req(b_req), .mem_we(b_we), .mem_word(b_word),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack & sel), .hit_cnt(b_hit), .miss_cnt(b_miss));

  assign o_ready = sel ? b_ready : a_ready;
  assign o_done  = sel ? b_done  : a_done;
  assign o_req   = sel ? b_req   : a_req;
  assign o_we    = sel ? b_we    : a_we;
  assign o_word  = sel ? b_word  : a_word;
  assign o_rdata = sel ? b_rdata : a_rdata;
  assign o_addr  = sel ? b_addr  : a_addr;
  assign o_wdata = sel ? b_wdata : a_wdata;
  assign o_hit   = sel ? b_hit   : a_hit;
  assign o_miss  = sel ? b_miss  : a_miss;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic push_mem(input logic we, input logic word, input logic [31:0] addr,
                          input logic [255:0] wd, input logic chk_wd,
                          input logic [255:0] rd, input int dly);
    mem_t m;
    m.we = we; m.word = word; m.addr = addr; m.wd = wd; m.chk_wd = chk_wd;
    m.rd = rd; m.dly = dly;
    exp_mem.push_back(m);
  endtask

  task automatic model_reset();
    exp_hits = 0; exp_misses = 0; last_rd = '0;
    exp_mem.delete(); exp_cpu.delete();
  endtask

  task automatic wait_ready();
    int cyc = 0;
    while (!o_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready_before_req", o_ready, 1'b1);
  endtask

  // Issue one request; memory transactions expected for it must already be queued.
  task automatic req(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rd_exp);
    cpu_t e;
    mem_t m;
    int   cyc, t_req, t_ack, nseen;
    bit   done_seen, in_req;
    e.rw    = rw;
    e.rdata = rw ? last_rd : rd_exp;
    if (exp_mem.size() == 0) begin exp_hits++;   e.lat = 3; end
    else                     begin exp_misses++; e.lat = 0; end
    if (!rw) last_rd = rd_exp;
    exp_cpu.push_back(e);

    wait_ready();
    cpu_valid = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wd;
    @(negedge clk);
    cpu_valid = 1'b0;
    cyc = 1; t_req = 0; t_ack = -10; nseen = 0; done_seen = 0; in_req = 0;
    m.dly = 0; m.rd = '0;
    while (!done_seen && cyc < 200) begin
      if (mem_ack) begin
        mem_ack = 1'b0;
        in_req  = 0;
        chk("mem_req_drop", o_req, 1'b0);
      end else if (o_req) begin
        if (!in_req) begin
          in_req = 1; t_req = cyc; nseen++;
          if (exp_mem.size() == 0) begin
            chk("unexpected_mem_req", o_req, 1'b0);
            m.dly = 0; m.rd = '0;
          end else begin
            m = exp_mem.pop_front();
            chk("mem_we", o_we, m.we);
            chk("mem_word", o_word, m.word);
            chk("mem_addr", o_addr, m.addr);
            if (m.chk_wd) chk("mem_wdata", o_wdata, m.wd);
            if (nseen > 1) chk("wb_refill_gap", cyc - t_ack, 2);
          end
        end
        if (in_req && (cyc - t_req) >= m.dly) begin
          mem_ack = 1'b1; mem_rdata = m.rd; t_ack = cyc;
        end
      end
      if (o_done) begin
        done_seen = 1;
        e = exp_cpu.pop_front();
        chk("cpu_rdata", o_rdata, e.rdata);
        if (e.lat > 0) chk("hit_latency", cyc, e.lat);
        chk("ready_during_done", o_ready, 1'b0);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done_seen) chk("done_timeout", done_seen, 1'b1);
    @(negedge clk);
    chk("ready_after_done", o_ready, 1'b1);
    chk("done_one_cycle", o_done, 1'b0);
    chk("hit_cnt", o_hit, exp_hits);
    chk("miss_cnt", o_miss, exp_misses);
    chk("mem_txn_left", exp_mem.size(), 0);
  endtask

  task automatic chk_reset_state(input string who);
    chk({who, "_ready"}, o_ready, 1'b1);
    chk({who, "_done"}, o_done, 1'b0);
    chk({who, "_rdata"}, o_rdata, 0);
    chk({who, "_mem_req"}, o_req, 1'b0);
    chk({who, "_mem_we"}, o_we, 1'b0);
    chk({who, "_mem_word"}, o_word, 1'b0);
    chk({who, "_mem_addr"}, o_addr, 0);
    chk({who, "_hit_cnt"}, o_hit, 0);
    chk({who, "_miss_cnt"}, o_miss, 0);
  endtask

  initial begin
    logic [255:0] wb_line;
    int           cyc;

    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    sel = 1'b1; #1 chk_reset_state("rst_b");
    sel = 1'b0; #1 chk_reset_state("rst_a");
    @(negedge clk);

    // Cold miss then hit on the same word.
    push_mem(1'b0, 1'b0, 32'h1040, '0, 1'b0, mk_line(32'hA0), 3);
    req(1'b0, 32'h1044, 32'h0, 32'hA1);
    req(1'b0, 32'h1044, 32'h0, 32'hA1);

    // Write hit then read back.
    req(1'b1, 32'h1048, 32'hDEADBEEF, 32'h0);
    req(1'b0, 32'h1048, 32'h0, 32'hDEADBEEF);

    // Fill set 2, refresh 0x1040, then evict the LRU clean line.
    push_mem(1'b0, 1'b0, 32'h1840, '0, 1'b0, mk_line(32'hB0), 0);
    req(1'b0, 32'h1840, 32'h0, 32'hB0);
    push_mem(1'b0, 1'b0, 32'h2040, '0, 1'b0, mk_line(32'hC0), 1);
    req(1'b0, 32'h2040, 32'h0, 32'hC0);
    push_mem(1'b0, 1'b0, 32'h2840, '0, 1'b0, mk_line(32'hD0), 2);
    req(1'b0, 32'h2840, 32'h0, 32'hD0);
    req(1'b0, 32'h1044, 32'h0, 32'hA1);
    push_mem(1'b0, 1'b0, 32'h3040, '0, 1'b0, mk_line(32'hE0), 0);
    req(1'b0, 32'h3040, 32'h0, 32'hE0);

    // Dirty 0x1040 becomes LRU and is written back before the refill.
    req(1'b0, 32'h2040, 32'h0, 32'hC0);
    req(1'b0, 32'h2840, 32'h0, 32'hD0);
    req(1'b0, 32'h3040, 32'h0, 32'hE0);
    wb_line = mk_line(32'hA0);
    wb_line[2*32 +: 32] = 32'hDEADBEEF;
    push_mem(1'b1, 1'b0, 32'h1040, wb_line, 1'b1, '0, 2);
    push_mem(1'b0, 1'b0, 32'h3840, '0, 1'b0, mk_line(32'hF0), 1);
    req(1'b0, 32'h3840, 32'h0, 32'hF0);
    push_mem(1'b0, 1'b0, 32'h1840, '0, 1'b0, mk_line(32'hB0), 0);
    req(1'b0, 32'h1840, 32'h0, 32'hB0);

    // Reset in the middle of a refill.
    wait_ready();
    cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h4040;
    @(negedge clk);
    cpu_valid = 1'b0;
    cyc = 0;
    while (!o_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_before_reset", o_req, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    chk("midrst_mem_req", o_req, 1'b0);
    chk("midrst_ready", o_ready, 1'b1);
    chk("midrst_done", o_done, 1'b0);
    chk("midrst_hit_cnt", o_hit, 0);
    chk("midrst_miss_cnt", o_miss, 0);
    push_mem(1'b0, 1'b0, 32'h1040, '0, 1'b0, mk_line(32'hA0), 0);
    req(1'b0, 32'h1044, 32'h0, 32'hA1);

    // Write-around instance.
    sel = 1'b1;
    model_reset();
    @(negedge clk);
    push_mem(1'b1, 1'b1, 32'h5004, 256'h12345678, 1'b1, '0, 2);
    req(1'b1, 32'h5004, 32'h12345678, 32'h0);
    push_mem(1'b0, 1'b0, 32'h5000, '0, 1'b0, mk_line(32'h50), 1);
    req(1'b0, 32'h5004, 32'h0, 32'h51);
    req(1'b1, 32'h5004, 32'hCAFEF00D, 32'h0);
    req(1'b0, 32'h5004, 32'h0, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
